// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator: column/line counters plus
// zero-latency registered blanking, sync and frame-start strobes.
module vga_timing #(
  parameter int unsigned HOR_TOTAL      = 1056,
  parameter int unsigned HOR_ACTIVE     = 800,
  parameter int unsigned HOR_SYNC_START = 840,
  parameter int unsigned HOR_SYNC_WIDTH = 128,
  parameter int unsigned VER_TOTAL      = 628,
  parameter int unsigned VER_ACTIVE     = 600,
  parameter int unsigned VER_SYNC_START = 601,
  parameter int unsigned VER_SYNC_WIDTH = 4,
  parameter int unsigned CNT_WIDTH      = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [CNT_WIDTH-1:0] hcount,
  output logic [CNT_WIDTH-1:0] vcount,
  output logic                 hblnk,
  output logic                 vblnk,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start
);

  localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(HOR_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] H_ACT  = CNT_WIDTH'(HOR_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] H_SS   = CNT_WIDTH'(HOR_SYNC_START);
  localparam logic [CNT_WIDTH-1:0] H_SE   = CNT_WIDTH'(HOR_SYNC_START + HOR_SYNC_WIDTH);
  localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(VER_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_ACT  = CNT_WIDTH'(VER_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_SS   = CNT_WIDTH'(VER_SYNC_START);
  localparam logic [CNT_WIDTH-1:0] V_SE   = CNT_WIDTH'(VER_SYNC_START + VER_SYNC_WIDTH);

  logic [CNT_WIDTH-1:0] hcount_q, hcount_d;
  logic [CNT_WIDTH-1:0] vcount_q, vcount_d;
  logic                 hblnk_q, hblnk_d;
  logic                 vblnk_q, vblnk_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 frame_start_q, frame_start_d;

  // Next counters; strobes decode the next position so they line up with it.
  always_comb begin
    hcount_d = '0;
    vcount_d = vcount_q;
    if (hcount_q < H_LAST) begin
      hcount_d = hcount_q + CNT_WIDTH'(1);
    end
    if (vcount_q > V_LAST) begin
      vcount_d = '0;
    end else if (hcount_q >= H_LAST) begin
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + CNT_WIDTH'(1);
    end
    hblnk_d       = (hcount_d >= H_ACT);
    vblnk_d       = (vcount_d >= V_ACT);
    hsync_d       = (hcount_d >= H_SS) && (hcount_d < H_SE);
    vsync_d       = (vcount_d >= V_SS) && (vcount_d < V_SE);
    frame_start_d = (hcount_d == '0) && (vcount_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
Free-running VGA raster timing generator at the head of the top_vga pixel pipeline, clocked by the 40 MHz pixel clock. It produces aligned horizontal and vertical counters, sync and blanking strobes, and a frame-start pulse. Downstream draw stages (background, board, cursor) consume these signals and forward hs/vs/rgb to the display and to the tiff_writer capture in simulation. Default timing is VESA 800x600 @ 60 Hz.

Parameters:
HOR_TOTAL, 1056, pixels per line including blanking
HOR_ACTIVE, 800, visible pixels per line; hblnk asserts from this count
HOR_SYNC_START, 840, first hcount with hsync high
HOR_SYNC_WIDTH, 128, hsync length in pixels
VER_TOTAL, 628, lines per frame including blanking
VER_ACTIVE, 600, visible lines; vblnk asserts from this count
VER_SYNC_START, 601, first vcount with vsync high
VER_SYNC_WIDTH, 4, vsync length in lines
CNT_WIDTH, 11, counter width; must satisfy 2**CNT_WIDTH >= max(HOR_TOTAL, VER_TOTAL)

Ports:
clk  in  1  pixel clock, 40 MHz
rst  in  1  synchronous active-high reset
hcount  out  CNT_WIDTH  current pixel column, 0..HOR_TOTAL-1
vcount  out  CNT_WIDTH  current line, 0..VER_TOTAL-1
hblnk  out  1  high when hcount >= HOR_ACTIVE
vblnk  out  1  high when vcount >= VER_ACTIVE
hsync  out  1  high when HOR_SYNC_START <= hcount < HOR_SYNC_START+HOR_SYNC_WIDTH
vsync  out  1  high when VER_SYNC_START <= vcount < VER_SYNC_START+VER_SYNC_WIDTH
frame_start  out  1  one-cycle pulse when counters wrap to (0,0)

Behaviour:
- One clock and one reset. Reset is synchronous and active-high. All outputs are registers. There are no combinational paths from inputs to outputs.
- Reset: while rst is sampled high, hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=0, vsync=0, frame_start=0. rst asserted mid-frame forces these values at the next edge, with no partial-line completion.
- Counting on each edge with rst=0:
  - hcount_next = (hcount==HOR_TOTAL-1) ? 0 : hcount+1.
  - vcount advances only when hcount wraps: vcount_next = (vcount==VER_TOTAL-1) ? 0 : vcount+1.
  - At the corner (hcount=HOR_TOTAL-1, vcount=VER_TOTAL-1), both counters wrap to 0 at the same edge.
- Alignment: the strobes are computed from hcount_next/vcount_next and registered in the same edge as the counters. In every cycle, the strobes describe the hcount/vcount values present in that same cycle, so latency is 0 relative to the counters.
- The first cycle after reset release shows hcount=1, vcount=0, all strobes 0. The counter was at 0 during reset.
- frame_start is registered high when the next counters are (0,0), excluding reset. It pulses for one cycle with hcount=0, vcount=0.
  - The first pulse occurs HOR_TOTAL*VER_TOTAL-1 cycles after the first non-reset edge.
  - Pulses then repeat every HOR_TOTAL*VER_TOTAL = 663168 cycles.
- Polarity: sync strobes are active-high, matching VESA 800x600. Any inversion for other modes is done downstream.
- Width: comparisons are unsigned at CNT_WIDTH bits. The sync end is computed as a constant (START+WIDTH) at elaboration.
- Counters never exceed TOTAL-1. Any out-of-range value is impossible from reset; if one occurs, the next edge wraps it to 0.

Test Plan:
- Reset: hold rst=1 for 5 cycles -> hcount=0, vcount=0, all strobes and frame_start 0. Release -> the next cycle shows hcount=1, vcount=0.
- Horizontal timing on line 0:
  - hblnk 0 for hcount 0..799 and 1 for 800..1055.
  - hsync rises with hcount=840 and falls with hcount=968, high for 128 cycles.
  - hcount goes 1055 -> 0 and vcount goes 0 -> 1 on the same edge.
- Vertical timing:
  - vblnk rises when vcount=600.
  - vsync is high for vcount 601..604, which is 4*1056=4224 cycles.
  - vblnk stays high through vcount=627.
- Frame wrap: at hcount=1055, vcount=627, the next edge gives (0,0) and frame_start=1 for exactly 1 cycle. The successive frame_start spacing is 663168 cycles. Assert the counters never reach 1056/628.
- Reset mid-frame: assert rst for 1 cycle at hcount=500, vcount=300 -> the next cycle gives all zeros. Timing then restarts, and the first frame_start arrives 663167 cycles after release.
- Checker: across 2 full frames, compare every output each cycle against a reference model built from the parameter formulas. Zero mismatches are required.
